fdma_rw_scheduler: RTL and testbench

//  Time-shares one half-duplex DDR port between the FDMA write path and the FDMA read path.

---
 rtl/fdma_rw_scheduler_if.sv | 13 +
 rtl/fdma_rw_scheduler.sv | 165 ++++++++++++++++
 tb/tb_fdma_rw_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdma_rw_scheduler_if.sv
// Command-channel bundle for one FDMA direction: address/size/request toward the
// consumer, busy back toward the requester.
interface fdma_rw_scheduler_if #(
    parameter int AW = 21
);
    logic [AW-1:0] addr;
    logic          areq;
    logic [15:0]   size;
    logic          busy;

    modport master (output addr, output areq, output size, input  busy);
    modport slave  (input  addr, input  areq, input  size, output busy);
endinterface

// File: rtl/fdma_rw_scheduler.sv
// Time-shares one half-duplex DDR port between the FDMA write and read paths:
// one transfer in flight, writes preferred up to a quota while a read waits.
module fdma_rw_scheduler #(
    parameter int AXI_ADDR_WIDTH = 21,
    parameter int WR_QUOTA       = 4,
    parameter int TO_W           = 16
) (
    input  logic                      ui_clk,
    input  logic                      ui_rstn,
    fdma_rw_scheduler_if.slave        up_w,
    fdma_rw_scheduler_if.slave        up_r,
    fdma_rw_scheduler_if.master       fdma_w,
    fdma_rw_scheduler_if.master       fdma_r,
    input  logic [TO_W-1:0]           issue_timeout,
    output logic                      err_timeout,
    output logic [2:0]                sched_state
);
    localparam int            CW    = $clog2(WR_QUOTA + 1);
    localparam logic [CW-1:0] QUOTA = CW'(WR_QUOTA);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_W_ISS = 3'd1;
    localparam logic [2:0] S_W_RUN = 3'd2;
    localparam logic [2:0] S_R_ISS = 3'd3;
    localparam logic [2:0] S_R_RUN = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [CW-1:0]             wr_cnt_q, wr_cnt_d;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
    logic                      wbusy_dly_q, rbusy_dly_q;
    logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [15:0]               wsize_q, wsize_d, rsize_q, rsize_d;
    logic                      wareq_q, wareq_d, rareq_q, rareq_d;
    logic                      up_wbusy_q, up_wbusy_d, up_rbusy_q, up_rbusy_d;
    logic                      err_q, err_d;
    logic                      timeout_hit;
    logic                      wr_grant, rd_grant;

    assign timeout_hit = (issue_timeout != '0) && (to_cnt_q == (issue_timeout - TO_W'(1)));

    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (up_w.areq && (!up_r.areq || (wr_cnt_q < QUOTA))) begin
                    state_d = S_W_ISS;
                end else if (up_r.areq) begin
                    state_d = S_R_ISS;
                end
            end
            S_W_ISS: begin
                if (fdma_w.busy) begin
                    state_d = S_W_RUN;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_W_RUN: begin
                if (wbusy_dly_q && !fdma_w.busy) begin
                    state_d = S_IDLE;
                end
            end
            S_R_ISS: begin
                if (fdma_r.busy) begin
                    state_d = S_R_RUN;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_R_RUN: begin
                if (rbusy_dly_q && !fdma_r.busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is a register decoded from the next state, so the
    // request/busy pairs are mutually exclusive by construction.
    always_comb begin
        wr_grant    = (state_q == S_IDLE) && (state_d == S_W_ISS);
        rd_grant    = (state_q == S_IDLE) && (state_d == S_R_ISS);
        waddr_d     = waddr_q;
        wsize_d     = wsize_q;
        raddr_d     = raddr_q;
        rsize_d     = rsize_q;
        wr_cnt_d    = wr_cnt_q;
        to_cnt_d    = '0;
        if (wr_grant) begin
            waddr_d = up_w.addr;
            wsize_d = up_w.size;
            if (up_r.areq) begin
                wr_cnt_d = (wr_cnt_q == QUOTA) ? wr_cnt_q : wr_cnt_q + CW'(1);
            end else begin
                wr_cnt_d = '0;
            end
        end
        if (rd_grant) begin
            raddr_d  = up_r.addr;
            rsize_d  = up_r.size;
            wr_cnt_d = '0;
        end
        if (((state_q == S_W_ISS) && (state_d == S_W_ISS)) ||
            ((state_q == S_R_ISS) && (state_d == S_R_ISS))) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        wareq_d    = (state_d == S_W_ISS);
        rareq_d    = (state_d == S_R_ISS);
        up_wbusy_d = (state_d == S_W_ISS) || (state_d == S_W_RUN);
        up_rbusy_d = (state_d == S_R_ISS) || (state_d == S_R_RUN);
        err_d      = ((state_q == S_W_ISS) || (state_q == S_R_ISS)) && (state_d == S_IDLE);
    end

    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            wr_cnt_q    <= '0;
            to_cnt_q    <= '0;
            wbusy_dly_q <= 1'b0;
            rbusy_dly_q <= 1'b0;
            waddr_q     <= '0;
            wsize_q     <= '0;
            raddr_q     <= '0;
            rsize_q     <= '0;
            wareq_q     <= 1'b0;
            rareq_q     <= 1'b0;
            up_wbusy_q  <= 1'b0;
            up_rbusy_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            to_cnt_q    <= to_cnt_d;
            wbusy_dly_q <= fdma_w.busy;
            rbusy_dly_q <= fdma_r.busy;
            waddr_q     <= waddr_d;
            wsize_q     <= wsize_d;
            raddr_q     <= raddr_d;
            rsize_q     <= rsize_d;
            wareq_q     <= wareq_d;
            rareq_q     <= rareq_d;
            up_wbusy_q  <= up_wbusy_d;
            up_rbusy_q  <= up_rbusy_d;
            err_q       <= err_d;
        end
    end

    assign fdma_w.addr  = waddr_q;
    assign fdma_w.size  = wsize_q;
    assign fdma_w.areq  = wareq_q;
    assign fdma_r.addr  = raddr_q;
    assign fdma_r.size  = rsize_q;
    assign fdma_r.areq  = rareq_q;
    assign up_w.busy    = up_wbusy_q;
    assign up_r.busy    = up_rbusy_q;
    assign err_timeout  = err_q;
    assign sched_state  = state_q;
endmodule

// File: tb/tb_fdma_rw_scheduler.sv
// Directed bench for fdma_rw_scheduler: a transaction-level owner/phase model is
// checked against the DUT every cycle, plus literal checks on each scenario.
module tb_fdma_rw_scheduler;
    localparam int AW    = 21;
    localparam int QUOTA = 4;

    logic        ui_clk  = 1'b0;
    logic        ui_rstn = 1'b0;
    logic [15:0] issue_timeout;
    logic        err_timeout;
    logic [2:0]  sched_state;
    logic [1:0]  resp_busy;
    logic [1:0]  man_busy;
    logic [1:0]  resp_en;
    int          resp_dly, resp_len;

    fdma_rw_scheduler_if #(.AW(AW)) up_w ();
    fdma_rw_scheduler_if #(.AW(AW)) up_r ();
    fdma_rw_scheduler_if #(.AW(AW)) fdma_w ();
    fdma_rw_scheduler_if #(.AW(AW)) fdma_r ();

    assign fdma_w.busy = resp_busy[0] | man_busy[0];
    assign fdma_r.busy = resp_busy[1] | man_busy[1];

    fdma_rw_scheduler #(.AXI_ADDR_WIDTH(AW), .WR_QUOTA(QUOTA), .TO_W(16)) dut (
        .ui_clk        (ui_clk),
        .ui_rstn       (ui_rstn),
        .up_w          (up_w),
        .up_r          (up_r),
        .fdma_w        (fdma_w),
        .fdma_r        (fdma_r),
        .issue_timeout (issue_timeout),
        .err_timeout   (err_timeout),
        .sched_state   (sched_state)
    );

    always #5 ui_clk = ~ui_clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the port (0 none, 1 write, 2 read),
    // whether that owner is still issuing, and the edge on which it was granted.
    int              m_owner = 0, m_edge = 0, m_grant_edge = 0, m_streak = 0;
    bit              m_iss = 0, m_err = 0, m_b = 0;
    bit              m_prev[2] = '{0, 0};
    logic [AW-1:0]   m_addr[2] = '{'0, '0};
    logic [15:0]     m_size[2] = '{'0, '0};

    initial forever begin
        @(posedge ui_clk or negedge ui_rstn);
        if (!ui_rstn) begin
            m_owner = 0; m_iss = 0; m_err = 0; m_streak = 0;
            m_prev  = '{0, 0};
            m_addr  = '{'0, '0};
            m_size  = '{'0, '0};
        end else begin
            m_edge++;
            m_err = 0;
            if (m_owner == 0) begin
                if (up_w.areq && (!up_r.areq || m_streak < QUOTA)) begin
                    m_owner = 1; m_iss = 1; m_grant_edge = m_edge;
                    m_addr[0] = up_w.addr; m_size[0] = up_w.size;
                    m_streak = up_r.areq ? ((m_streak < QUOTA) ? m_streak + 1 : QUOTA) : 0;
                end else if (up_r.areq) begin
                    m_owner = 2; m_iss = 1; m_grant_edge = m_edge;
                    m_addr[1] = up_r.addr; m_size[1] = up_r.size;
                    m_streak = 0;
                end
            end else begin
                m_b = (m_owner == 1) ? fdma_w.busy : fdma_r.busy;
                if (m_iss) begin
                    if (m_b) begin
                        m_iss = 0;
                    end else if (issue_timeout != 0 && (m_edge - m_grant_edge) == int'(issue_timeout)) begin
                        m_owner = 0; m_iss = 0; m_err = 1;
                    end
                end else if (m_prev[m_owner-1] && !m_b) begin
                    m_owner = 0;
                end
            end
            m_prev[0] = fdma_w.busy;
            m_prev[1] = fdma_r.busy;
        end
    end

    function automatic int exp_state();
        if (m_owner == 0) return 0;
        if (m_owner == 1) return m_iss ? 1 : 2;
        return m_iss ? 3 : 4;
    endfunction

    // Per-cycle compare plus grant/timing bookkeeping used by the scenarios.
    int  ncyc = 0, wareq_rise = -1, err_cyc = -1;
    int  dut_log[$];
    bit  pw_busy = 0, pr_busy = 0, pw_areq = 0, w_busy_seen = 0;

    initial forever begin
        @(negedge ui_clk);
        ncyc++;
        if (chk_en) begin
            chk("state",     32'(sched_state),  32'(exp_state()));
            chk("w_areq",    32'(fdma_w.areq),  32'(m_owner == 1 && m_iss));
            chk("r_areq",    32'(fdma_r.areq),  32'(m_owner == 2 && m_iss));
            chk("up_wbusy",  32'(up_w.busy),    32'(m_owner == 1));
            chk("up_rbusy",  32'(up_r.busy),    32'(m_owner == 2));
            chk("w_addr",    32'(fdma_w.addr),  32'(m_addr[0]));
            chk("w_size",    32'(fdma_w.size),  32'(m_size[0]));
            chk("r_addr",    32'(fdma_r.addr),  32'(m_addr[1]));
            chk("r_size",    32'(fdma_r.size),  32'(m_size[1]));
            chk("err",       32'(err_timeout),  32'(m_err));
            chk("areq_excl", 32'(fdma_w.areq & fdma_r.areq), 32'(0));
            chk("busy_excl", 32'(up_w.busy & up_r.busy),     32'(0));
        end
        if (up_w.busy && !pw_busy) dut_log.push_back(1);
        if (up_r.busy && !pr_busy) dut_log.push_back(2);
        if (fdma_w.areq && !pw_areq) wareq_rise = ncyc;
        if (err_timeout) err_cyc = ncyc;
        if (up_w.busy) w_busy_seen = 1;
        pw_busy = up_w.busy;
        pr_busy = up_r.busy;
        pw_areq = fdma_w.areq;
    end

    // FDMA responder: raises busy resp_dly cycles after seeing a request, holds it resp_len cycles.
    int r_phase[2] = '{0, 0};
    int r_cnt[2]   = '{0, 0};
    initial begin
        resp_busy = 2'b00;
        forever begin
            @(posedge ui_clk);
            #2;
            for (int s = 0; s < 2; s++) begin
                if (!ui_rstn) begin
                    r_phase[s] = 0;
                    resp_busy[s] = 1'b0;
                end else begin
                    case (r_phase[s])
                        0: if (resp_en[s] && (s == 0 ? fdma_w.areq : fdma_r.areq)) begin
                               if (resp_dly == 0) begin
                                   resp_busy[s] = 1'b1; r_cnt[s] = resp_len; r_phase[s] = 2;
                               end else begin
                                   r_cnt[s] = resp_dly; r_phase[s] = 1;
                               end
                           end
                        1: begin
                               r_cnt[s]--;
                               if (r_cnt[s] == 0) begin
                                   resp_busy[s] = 1'b1; r_cnt[s] = resp_len; r_phase[s] = 2;
                               end
                           end
                        default: begin
                               r_cnt[s]--;
                               if (r_cnt[s] <= 0) begin
                                   resp_busy[s] = 1'b0; r_phase[s] = 0;
                               end
                           end
                    endcase
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ui_clk);
        #2;
    endtask

    task automatic wait_neg();
        @(negedge ui_clk);
        #1;
    endtask

    task automatic wait_state(input int st, input int maxc, input string nm);
        for (int i = 0; i < maxc && int'(sched_state) != st; i++) wait_neg();
        chk(nm, 32'(sched_state), 32'(st));
    endtask

    task automatic wait_grants(input int n, input int maxc, input string nm);
        for (int i = 0; i < maxc && dut_log.size() < n; i++) wait_neg();
        chk(nm, 32'(dut_log.size()), 32'(n));
    endtask

    int exp_order[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    initial begin
        up_w.addr = '0; up_w.size = '0; up_w.areq = 1'b0;
        up_r.addr = '0; up_r.size = '0; up_r.areq = 1'b0;
        issue_timeout = 16'd0;
        man_busy = 2'b00;
        resp_en  = 2'b11;
        resp_dly = 1;
        resp_len = 4;

        tick(3);
        chk_en = 1;
        chk("rst_state", 32'(sched_state), 32'(0));
        chk("rst_wbusy", 32'(up_w.busy), 32'(0));
        ui_rstn = 1'b1;
        tick(2);

        // Single write, 64 beats
        up_w.addr = 21'h00100; up_w.size = 16'd64; up_w.areq = 1'b1;
        @(posedge ui_clk); #1;
        chk("t1_wareq_lat", 32'(fdma_w.areq), 32'(1));
        chk("t1_wsize",     32'(fdma_w.size), 32'(64));
        #1;
        up_w.areq = 1'b0;
        for (int i = 0; i < 20 && !fdma_w.busy; i++) wait_neg();
        @(posedge ui_clk); #1;
        chk("t1_areq_clr", 32'(fdma_w.areq), 32'(0));
        chk("t1_run",      32'(sched_state), 32'(2));
        wait_state(0, 50, "t1_idle");
        chk("t1_wbusy_off", 32'(up_w.busy), 32'(0));

        // Spurious read busy while idle
        tick(1);
        man_busy = 2'b10;
        tick(2);
        man_busy = 2'b00;
        chk("spur_idle", 32'(sched_state), 32'(0));
        tick(2);

        // Both requesters held: quota-bounded write priority
        dut_log.delete();
        resp_dly = 1; resp_len = 3;
        up_w.addr = 21'h00200; up_w.size = 16'd16;
        up_r.addr = 21'h0AAAA; up_r.size = 16'd32;
        up_w.areq = 1'b1; up_r.areq = 1'b1;
        wait_grants(10, 400, "t2_grants");
        @(posedge ui_clk); #2;
        up_w.areq = 1'b0; up_r.areq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < dut_log.size()) chk($sformatf("t2_order%0d", i), 32'(dut_log[i]), 32'(exp_order[i]));
        end
        wait_state(0, 100, "t2_idle");
        tick(2);

        // Read only, three back-to-back
        dut_log.delete();
        w_busy_seen = 0;
        up_r.addr = 21'h01234; up_r.size = 16'd8; up_r.areq = 1'b1;
        wait_grants(3, 200, "t3_grants");
        @(posedge ui_clk); #2;
        up_r.areq = 1'b0;
        wait_state(0, 100, "t3_idle");
        for (int i = 0; i < 3; i++) begin
            if (i < dut_log.size()) chk($sformatf("t3_side%0d", i), 32'(dut_log[i]), 32'(2));
        end
        chk("t3_no_wbusy", 32'(w_busy_seen), 32'(0));
        tick(2);

        // Issue timeout with write busy stuck low, read pending
        dut_log.delete();
        issue_timeout = 16'd10;
        resp_en = 2'b10;
        err_cyc = -1;
        up_w.addr = 21'h00777; up_w.size = 16'd4; up_w.areq = 1'b1;
        up_r.addr = 21'h00555; up_r.size = 16'd4; up_r.areq = 1'b1;
        for (int i = 0; i < 20 && !up_w.busy; i++) wait_neg();
        @(posedge ui_clk); #2;
        up_w.areq = 1'b0;
        for (int i = 0; i < 40 && err_cyc < 0; i++) wait_neg();
        chk("t4_err_delay", 32'(err_cyc - wareq_rise), 32'(10));
        wait_grants(2, 20, "t4_grants");
        if (dut_log.size() >= 2) chk("t4_read_next", 32'(dut_log[1]), 32'(2));
        @(posedge ui_clk); #2;
        up_r.areq = 1'b0;
        wait_state(0, 100, "t4_idle");
        issue_timeout = 16'd0;
        resp_en = 2'b11;
        tick(2);

        // Reset asserted during W_RUN
        resp_len = 20;
        up_w.addr = 21'h00ABC; up_w.size = 16'd99; up_w.areq = 1'b1;
        wait_state(2, 50, "t5_run");
        @(posedge ui_clk); #2;
        up_w.areq = 1'b0;
        #1;
        ui_rstn = 1'b0;
        #1;
        chk("t5_async_state", 32'(sched_state), 32'(0));
        chk("t5_async_wbusy", 32'(up_w.busy),   32'(0));
        chk("t5_async_addr",  32'(fdma_w.addr), 32'(0));
        chk("t5_async_size",  32'(fdma_w.size), 32'(0));
        tick(2);
        ui_rstn = 1'b1;
        wait_neg();
        chk("t5_post_idle", 32'(sched_state), 32'(0));
        tick(2);

        // Address captured at grant and held through W_RUN
        resp_len = 8;
        up_w.addr = 21'h1ABCD; up_w.size = 16'd16; up_w.areq = 1'b1;
        wait_state(2, 50, "t6_run");
        @(posedge ui_clk); #2;
        up_w.areq = 1'b0;
        up_w.addr = 21'h00042;
        man_busy = 2'b10;
        tick(2);
        man_busy = 2'b00;
        chk("t6_addr_hold", 32'(fdma_w.addr), 32'(21'h1ABCD));
        chk("t6_spur_run",  32'(sched_state), 32'(2));
        wait_state(0, 50, "t6_idle");
        chk("t6_addr_idle", 32'(fdma_w.addr), 32'(21'h1ABCD));

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
